// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and helpers for the instruction fetch unit
// Purpose: word/entry types and word-address helpers used by inst_fetch_unit and fetch_fifo.
// Ports: none (package).
package fetch_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t pc;
        word_t inst;
    } fetch_entry_t;

    localparam int WORD_BYTES = 4;

    // Instruction fetches are always word aligned; low address bits are discarded.
    function automatic word_t align_word(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Next sequential word address; wraps 0xFFFF_FFFC -> 0x0000_0000.
    function automatic word_t next_word(input word_t addr);
        return addr + word_t'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO holding {pc, instruction} entries
// Purpose: small power-of-two FIFO between instruction memory responses and the CPU.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   push       in   write push_data this cycle
//   push_data  in   entry to write
//   pop        in   remove head entry this cycle (ignored when empty)
//   flush      in   synchronous clear; overrides push and pop
//   head       out  current head entry, zero when empty
//   count      out  number of valid entries
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    fetch_entry_t      r_mem [DEPTH];
    logic [AW-1:0]     r_rd_ptr;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW:0]       r_count;

    logic              w_pop;

    // A pop on an empty FIFO is harmless and simply ignored.
    assign w_pop = pop & (r_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            unique case ({push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while counted valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign count = r_count;

    // The fetch credit scheme keeps the FIFO from ever being written while full.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && !w_pop && (r_count == CNT_FULL)));

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - PC generation, instruction memory requests and prefetch buffering
// Purpose: issues word-aligned fetches under a credit limit, buffers in-order responses in
//   fetch_fifo and hands them to the CPU with a valid/ready handshake; redirects flush all.
// Optional: FETCH_PERF_EN adds fetch_count / stall_count performance counters.
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   redirect_valid/addr  CPU fetch-stream restart and new PC (low 2 bits ignored)
//   imem_req/addr/gnt    request channel to instruction memory
//   imem_rvalid/rdata    in-order response channel from instruction memory
//   inst_valid/ready     instruction handshake to CPU, with inst and inst_pc
//   fetch_count          (FETCH_PERF_EN) instructions accepted by the CPU, saturating
//   stall_count          (FETCH_PERF_EN) cycles CPU was ready with no instruction, saturating
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter word_t RESET_ADDR = 32'h0000_0000,
    parameter int    DEPTH      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    word_t           r_fetch_pc;
    word_t           r_rsp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop;

    logic [CW-1:0]   w_fifo_count;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_entry;
    logic [CW:0]     w_used;
    logic            w_acc;
    logic            w_rsp;
    logic            w_rsp_keep;
    logic            w_pop;
    logic [CW-1:0]   w_out_next;

    // Buffered plus in-flight fetches may never exceed the FIFO size, so every
    // response always has a slot waiting for it.
    assign w_used    = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
    assign imem_req  = rst & (w_used < DEPTH_W);
    assign imem_addr = r_fetch_pc;

    assign w_acc      = imem_req & imem_gnt;
    // Stray responses with nothing outstanding are ignored rather than underflowing.
    assign w_rsp      = imem_rvalid & (r_outstanding != '0);
    assign w_rsp_keep = w_rsp & (r_drop == '0) & ~redirect_valid;
    assign w_pop      = inst_valid & inst_ready & ~redirect_valid;

    assign w_out_next = r_outstanding
                      + (w_acc ? CNT_ONE : '0)
                      - (w_rsp ? CNT_ONE : '0);

    assign w_push_entry = '{pc: r_rsp_pc, inst: imem_rdata};

    // r_rsp_pc tracks the address of the next kept response: it restarts at the
    // redirect target because every older response is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc    <= align_word(RESET_ADDR);
            r_rsp_pc      <= align_word(RESET_ADDR);
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (redirect_valid) begin
                r_fetch_pc <= align_word(redirect_addr);
                r_rsp_pc   <= align_word(redirect_addr);
                // Everything still in flight after this cycle, including a
                // request granted now, belongs to the abandoned stream.
                r_drop     <= w_out_next;
            end else begin
                if (w_acc) begin
                    r_fetch_pc <= next_word(r_fetch_pc);
                end
                if (w_rsp_keep) begin
                    r_rsp_pc <= next_word(r_rsp_pc);
                end
                if (w_rsp && (r_drop != '0)) begin
                    r_drop <= r_drop - CNT_ONE;
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (w_rsp_keep),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .flush     (redirect_valid),
        .head      (w_head),
        .count     (w_fifo_count)
    );

    assign inst_valid = (w_fifo_count != '0);
    assign inst       = w_head.inst;
    assign inst_pc    = w_head.pc;

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (inst_valid && inst_ready && (r_fetch_count != 32'hFFFF_FFFF)) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (inst_ready && !inst_valid && (r_stall_count != 32'hFFFF_FFFF)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign fetch_count = r_fetch_count;
    assign stall_count = r_stall_count;
`endif

    a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst)
        imem_rvalid |-> (r_outstanding != '0));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - directed self-checking bench for inst_fetch_unit
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [31:0] inst_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int checks = 0;
    int errors = 0;

    int          lat = 1;
    bit          gnt_block = 1'b0;
    int          tnow = 0;
    int          acc_total = 0;
    logic [31:0] q_addr [$];
    int          q_due [$];

    always #5 clk = ~clk;

    inst_fetch_unit #(
        .RESET_ADDR (32'h0000_0000),
        .DEPTH      (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count    (fetch_count),
        .stall_count    (stall_count)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'hE3A02007;
            32'h0000_0004: return 32'hE1A03002;
            32'h0000_0008: return 32'hE0825003;
            default:       return 32'hE280_0000 | {20'h0, a[11:0]};
        endcase
    endfunction

    // Memory model: updates 1 time unit after each falling edge; a request granted at
    // the next rising edge returns its data 'lat' model steps later, in order.
    always @(negedge clk) begin
        #1;
        tnow++;
        if (!rst) begin
            q_addr.delete();
            q_due.delete();
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
            imem_gnt    = 1'b0;
        end else begin
            if (q_addr.size() > 0 && q_due[0] <= tnow) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(q_addr.pop_front());
                void'(q_due.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'hDEAD_BEEF;
            end
            imem_gnt = !gnt_block;
            if (imem_req && imem_gnt) begin
                q_addr.push_back(imem_addr);
                q_due.push_back(tnow + lat);
                acc_total++;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Returns on the falling edge at which rst is released.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
        checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 00000000", inst); end
        checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 00000000", inst_pc); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 00000000", imem_addr); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'hE3A02007;
        exp_w[1] = 32'hE1A03002;
        exp_w[2] = 32'hE0825003;
        inst_ready = 1'b1; lat = 1; gnt_block = 1'b0;
        tick();
        rst = 1'b1;
        #2;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL seq_first_req: got %b expected 1", imem_req); end
        tick();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL seq_early_valid: got %b expected 0", inst_valid); end
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL seq_valid%0d: got %b expected 1", i, inst_valid); end
            checks++; if (inst !== exp_w[i]) begin errors++; $display("FAIL seq_inst%0d: got %h expected %h", i, inst, exp_w[i]); end
            checks++; if (inst_pc !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc%0d: got %h expected %h", i, inst_pc, 32'(4 * i)); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int acc0;
        inst_ready = 1'b0; lat = 1; gnt_block = 1'b0;
        do_reset();
        acc0 = acc_total;
        repeat (10) tick();
        checks++; if (acc_total - acc0 !== 4) begin errors++; $display("FAIL bp_req_count: got %0d expected 4", acc_total - acc0); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_low: got %b expected 0", imem_req); end
        inst_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL bp_valid%0d: got %b expected 1", i, inst_valid); end
            checks++; if (inst_pc !== 32'(4 * i)) begin errors++; $display("FAIL bp_pc%0d: got %h expected %h", i, inst_pc, 32'(4 * i)); end
            checks++; if (inst !== mem_word(32'(4 * i))) begin errors++; $display("FAIL bp_inst%0d: got %h expected %h", i, inst, mem_word(32'(4 * i))); end
            if (i == 1) begin
                checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL bp_resume_req: got %b expected 1", imem_req); end
            end
            tick();
        end
    endtask

    task automatic test_gnt_stall();
        inst_ready = 1'b1; lat = 1; gnt_block = 1'b0;
        do_reset();
        tick();
        tick();
        gnt_block = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            if (i == 3) gnt_block = 1'b0;
            checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL gnt_hold_addr%0d: got %h expected 00000008", i, imem_addr); end
            checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL gnt_hold_req%0d: got %b expected 1", i, imem_req); end
        end
        tick();
        checks++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL gnt_next_addr: got %h expected 0000000c", imem_addr); end
    endtask

    task automatic test_redirect_drop();
        inst_ready = 1'b1; lat = 3; gnt_block = 1'b0;
        do_reset();
        tick();
        tick();
        gnt_block = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        gnt_block = 1'b0;
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL rd_addr: got %h expected 00000100", imem_addr); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rd_req: got %b expected 1", imem_req); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rd_dropped%0d: got %b expected 0", i, inst_valid); end
        end
        tick();
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL rd_valid: got %b expected 1", inst_valid); end
        checks++; if (inst_pc !== 32'h100) begin errors++; $display("FAIL rd_pc: got %h expected 00000100", inst_pc); end
        checks++; if (inst !== 32'hE2800100) begin errors++; $display("FAIL rd_inst: got %h expected e2800100", inst); end
        lat = 1;
    endtask

    task automatic test_redirect_same_cycle();
        inst_ready = 1'b1; lat = 1; gnt_block = 1'b0;
        do_reset();
        tick();
        tick();
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL rs_pre_valid: got %b expected 1", inst_valid); end
        redirect_valid = 1'b1;
        redirect_addr = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rs_flushed: got %b expected 0", inst_valid); end
        checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL rs_addr: got %h expected 00000200", imem_addr); end
        tick();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rs_drop_granted: got %b expected 0", inst_valid); end
        tick();
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL rs_valid: got %b expected 1", inst_valid); end
        checks++; if (inst_pc !== 32'h200) begin errors++; $display("FAIL rs_pc: got %h expected 00000200", inst_pc); end
        checks++; if (inst !== 32'hE2800200) begin errors++; $display("FAIL rs_inst: got %h expected e2800200", inst); end
    endtask

    task automatic test_wrap();
        inst_ready = 1'b1; lat = 1; gnt_block = 1'b0;
        do_reset();
        redirect_valid = 1'b1;
        redirect_addr = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h expected fffffffc", imem_addr); end
        tick();
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next: got %h expected 00000000", imem_addr); end
        tick();
        checks++; if (inst_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc0: got %h expected fffffffc", inst_pc); end
        checks++; if (inst !== 32'hE2800FFC) begin errors++; $display("FAIL wrap_inst0: got %h expected e2800ffc", inst); end
        tick();
        checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL wrap_pc1: got %h expected 00000000", inst_pc); end
        checks++; if (inst !== 32'hE3A02007) begin errors++; $display("FAIL wrap_inst1: got %h expected e3a02007", inst); end
    endtask

    task automatic test_async_reset();
        tick();
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid: got %b expected 1", inst_valid); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b expected 0", inst_valid); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ar_req: got %b expected 0", imem_req); end
        checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL ar_pc: got %h expected 00000000", inst_pc); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL ar_addr: got %h expected 00000000", imem_addr); end
        tick();
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        inst_ready = 1'b1; lat = 1;
        do_reset();
        gnt_block = 1'b1;
        tick();
        gnt_block = 1'b0;
        repeat (7) tick();
        inst_ready = 1'b0;
        checks++; if (fetch_count !== 32'd5) begin errors++; $display("FAIL perf_fetch: got %0d expected 5", fetch_count); end
        checks++; if (stall_count !== 32'd3) begin errors++; $display("FAIL perf_stall: got %0d expected 3", stall_count); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL perf_fetch_rst: got %0d expected 0", fetch_count); end
        checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL perf_stall_rst: got %0d expected 0", stall_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_gnt_stall();
        test_redirect_drop();
        test_redirect_same_cycle();
        test_wrap();
        test_async_reset();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Upstream neighbour of CPU: generates the program counter and issues word-aligned requests to instruction memory.
- Buffers returned ARM instruction words in a small prefetch FIFO and presents them to the CPU's inst input with a valid/ready handshake.
- Supports redirects (branch or exception) from the CPU by flushing all in-flight and buffered fetches.

Parameters:
- RESET_ADDR, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- DEPTH, 4, prefetch FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  CPU requests a fetch-stream restart.
- redirect_addr  in  32  new PC; bits [1:0] are ignored and forced to 0.
- imem_req  out  1  memory request valid.
- imem_addr  out  32  request address, word aligned.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid; responses return in order.
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  inst/inst_pc hold a valid instruction.
- inst_ready  in  1  CPU consumes the instruction this cycle.
- inst  out  32  instruction word to CPU.
- inst_pc  out  32  address of inst.

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_ADDR, imem_req=0, inst_valid=0, inst=0, inst_pc=0.
  - FIFO empty, outstanding=0, drop=0.
- Credit rule:
  - imem_req=1 iff fifo_count + outstanding < DEPTH and not in reset.
  - First imem_req asserts in the first cycle after rst deasserts.
- Request handshake:
  - Accepted when imem_req & imem_gnt; then fetch_pc += 4 (32-bit wrap, 0xFFFF_FFFC -> 0) and outstanding++.
  - While imem_req=1 and imem_gnt=0, imem_addr is held stable; it may change only on redirect.
- Response handling:
  - imem_rvalid with drop=0: {fetch address, rdata} is pushed into the FIFO and outstanding--.
  - Each response's address is tracked in a parallel in-order address queue, or derived from a response PC counter.
  - With drop>0: the response is discarded, drop-- and outstanding--.
  - A response without an outstanding request is a protocol error; it is covered by an assertion and is not handled.
- Output:
  - inst/inst_pc/inst_valid are driven from the FIFO head register.
  - Pop when inst_valid & inst_ready.
  - Minimum latency rvalid -> inst_valid is 1 cycle; there is no combinational path from imem_rdata to inst.
  - Push and pop in the same cycle are both performed; the count is unchanged.
  - FIFO full never occurs because of the credit rule; overflow is covered by an assertion.
- Redirect (priority over every other event in the same cycle):
  - FIFO cleared; any pop that cycle is ignored.
  - fetch_pc = {redirect_addr[31:2], 2'b00}.
  - drop = outstanding minus any response arriving that cycle; that response is dropped.
  - A request granted in the redirect cycle is also counted into drop.
  - imem_req follows the credit rule next cycle, using the new address.
  - Zero-wait memory timing: redirect at cycle N -> req at N+1 -> rvalid at N+2 -> inst_valid at N+3.
- Reset mid-operation clears all state immediately; responses arriving after reset are ignored because outstanding=0.
- Sequential stream: inst_pc increments by 4 between consecutive accepted instructions unless a redirect intervenes.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined:
  - Adds outputs fetch_count[31:0] (instructions accepted by the CPU) and stall_count[31:0] (cycles with inst_ready=1 and inst_valid=0).
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
- When undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package fetch_pkg:
  - word_t (logic [31:0]).
  - fetch_entry_t struct {word_t pc; word_t inst;}.
  - WORD_BYTES=4.
  - Function align_word().
- Sub-module fetch_fifo (parameter DEPTH, entry type fetch_entry_t):
  - Ports: push, pop, flush, head, count.
  - Synchronous flush; asynchronous active-low reset.
- Top level holds the PC, the credit/drop counters and the handshakes.

Test Plan:
- Zero-wait memory returning E3A02007, E1A03002, E0825003, inst_ready=1 -> inst sequence identical, inst_pc 0x0, 0x4, 0x8 starting 2 cycles after rst release.
- inst_ready=0 for 10 cycles -> exactly DEPTH=4 requests issued, imem_req drops to 0; release -> 4 instructions at consecutive cycles, then fetching resumes.
- imem_gnt held 0 for 3 cycles with imem_addr=0x8 -> imem_addr stays 0x8, no PC advance; gnt=1 -> next addr 0xC.
- Two requests outstanding at 3-cycle memory latency, redirect_addr=0x103 -> both responses dropped; next imem_addr=0x100, first inst_pc=0x100.
- Redirect in the same cycle as imem_rvalid and inst_ready -> response discarded, FIFO empty next cycle, inst_valid=0.
- FETCH_PERF_EN defined: 5 instructions accepted, 3 stall cycles -> fetch_count=5, stall_count=3; rst pulse -> both 0.
